cascade_down_counter: RTL
=========================

Name: cascade_down_counter

Overview:
Loadable synchronous down-counter built as a chain of NIBBLES 4-bit stages with per-stage borrow ripple. It is the count-down companion to our 4-bit up-counter stage. It provides a borrow output (BO) for cascading further stages, an optional auto-reload from a captured reload value, and a registered terminal-count pulse for timer and prescaler use.

Parameters:
NIBBLES, 2, number of 4-bit stages; counter width W = 4*NIBBLES (legal range 1..8)

Ports:
CLK  input  1  clock; all state updates on the rising edge
CLR  input  1  reset: synchronous, active-high; clears all state
D  input  W  parallel load value
LOAD_n  input  1  active-low parallel load enable (synchronous)
ENP  input  1  count enable, parallel
ENT  input  1  count enable, trickle; also gates BO
RELOAD_EN  input  1  1 = on underflow reload from reload register; 0 = wrap to all-ones
Q  output  W  counter value
BO  output  1  borrow out, combinational: ENT & (Q == 0)
TC_PULSE  output  1  registered one-cycle pulse after an underflow count event
ZERO  output  1  combinational: Q == 0, independent of ENT

Behaviour:
- Reset: CLK is the only clock. CLR is synchronous and active-high. When CLR=1 at a rising edge: Q=0, reload register R=0, TC_PULSE=0. CLR overrides every other input.
- Resulting outputs after reset: ZERO=1; BO equals ENT.
- Priority at each rising edge: CLR, then LOAD_n=0, then count, then hold.
- Load (LOAD_n=0, CLR=0): Q<=D and R<=D in the same edge. ENP, ENT and RELOAD_EN are ignored. TC_PULSE<=0.
- Count event: LOAD_n=1 & ENP=1 & ENT=1.
  - Q!=0: Q<=Q-1, modulo 2^W.
  - Q==0 & RELOAD_EN=1: Q<=R.
  - Q==0 & RELOAD_EN=0: Q<=all ones.
  - TC_PULSE<=1 on the edge of any count event taken with Q==0; otherwise TC_PULSE<=0.
- Hold: with no count event (ENP=0 or ENT=0), Q and R are unchanged and TC_PULSE<=0.
- TC_PULSE stays high for exactly one cycle per underflow. Back-to-back underflows (R=0 with RELOAD_EN=1) produce TC_PULSE high on consecutive cycles.
- Stage structure: stage k (Q[4k+3:4k]) decrements only when ENP & ENT & (all lower stages == 0). Otherwise it holds.
  - Each stage produces its own borrow signal: stage_bo[k] = stage_en[k] & (stage k == 0). This feeds stage k+1.
  - The observable result must equal a W-bit decrement.
- Borrow chain: BO = ENT & ZERO. It is purely combinational, with no dependency on ENP, LOAD_n or CLK. This lets BO drive ENT of a further external stage.
- Boundaries:
  - Nibble crossing: 0x10 -> 0x0F in one edge.
  - Full underflow: 0x00 -> 0xFF with RELOAD_EN=0, or 0x00 -> R with RELOAD_EN=1.
  - Load with D=0: Q=0, BO=ENT the same cycle, TC_PULSE stays 0.
  - CLR and LOAD_n=0 in the same edge: CLR wins, so Q=0 and R=0.
  - CLR in the middle of counting: the next edge gives Q=0 and R=0; counting resumes from 0 on the following event.
- Changing RELOAD_EN takes effect at the next edge; it has no effect except on an underflow.

Test Plan:
1. Reset/clear (NIBBLES=2): CLR=1 for one edge with ENP=ENT=1 and LOAD_n=0, D=0x5A -> Q=0x00, TC_PULSE=0, ZERO=1, BO=1. Then drop ENT -> BO=0 and ZERO=1.
2. Load and count across nibble: load D=0x12, then ENP=ENT=1 for 3 edges -> Q=0x11, 0x10, 0x0F. TC_PULSE stays 0 throughout. ZERO and BO stay 0 throughout.
3. Wrap underflow: load 0x01, RELOAD_EN=0, count 2 edges -> Q=0x00 with BO=1, then Q=0xFF. TC_PULSE=1 for exactly the cycle after the 0x00 -> 0xFF edge.
4. Auto-reload: load 0x03, RELOAD_EN=1, count 8 edges -> Q sequence 2,1,0,3,2,1,0,3. TC_PULSE high after edges 4 and 8 only.
5. Enable gating: Q=0x40; toggle ENP=0/ENT=1, then ENP=1/ENT=0, 3 edges each -> Q holds 0x40. At Q=0x00 with ENT=0 -> BO=0, ZERO=1, and Q holds.
6. Simultaneous events: Q=0x00 with ENP=ENT=1 and LOAD_n=0, D=0x77 -> Q=0x77 and TC_PULSE=0. Then CLR=1 with LOAD_n=0 -> Q=0x00 and R=0x00. Then RELOAD_EN=1 with two count edges -> Q=0x00, 0x00 with TC_PULSE high both cycles.

Source files
------------

// File: rtl/cascade_down_counter.sv
// cascade_down_counter: loadable down-counter of 4-bit stages with borrow ripple, auto-reload and terminal-count pulse
module cascade_down_counter #(
    parameter int NIBBLES = 2,
    localparam int W = 4 * NIBBLES
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic [W-1:0] D,
    input  logic         LOAD_n,
    input  logic         ENP,
    input  logic         ENT,
    input  logic         RELOAD_EN,
    output logic [W-1:0] Q,
    output logic         BO,
    output logic         TC_PULSE,
    output logic         ZERO
);
    logic [W-1:0] r;
    logic [W-1:0] q_dec;
    logic         underflow;

    assign ZERO = Q == '0;
    assign BO   = ENT & ZERO;

    // Borrow ripples upward: a stage steps only when every lower stage is zero
    always_comb begin
        logic [NIBBLES:0] stage_en;
        stage_en = '0;
        q_dec = Q;
        stage_en[0] = ENP & ENT;
        for (int k = 0; k < NIBBLES; k++) begin
            q_dec[4*k +: 4] = stage_en[k] ? Q[4*k +: 4] - 4'd1 : Q[4*k +: 4];
            stage_en[k+1] = stage_en[k] & (Q[4*k +: 4] == 4'd0);
        end
        underflow = stage_en[NIBBLES];
    end

    // Clear beats load beats count; an underflow either wraps or reloads from r
    always_ff @(posedge CLK) begin
        if (CLR) begin
            Q <= '0;
            r <= '0;
            TC_PULSE <= 1'b0;
        end else if (!LOAD_n) begin
            Q <= D;
            r <= D;
            TC_PULSE <= 1'b0;
        end else begin
            Q <= (underflow && RELOAD_EN) ? r : q_dec;
            TC_PULSE <= underflow;
        end
    end
endmodule
